// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod
//   Parametrised synchronous modulo-MODULUS up/down counter with count enable,
//   direction control, parallel load, optional one-shot halt and a
//   terminal-count output for cascading stages.
//
// Parameters
//   WIDTH    count register width (>= 1)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   ONESHOT  0: wrap at terminal, 1: halt at terminal until load/reset
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   en        in   count enable
//   up_dn     in   1 = up, 0 = down
//   load      in   parallel load strobe
//   load_val  in   value to load (rejected if >= MODULUS)
//   count     out  registered count
//   tc        out  terminal count, combinational (feeds next stage en)
//   done      out  one-shot halted flag, registered
//   load_err  out  one-cycle pulse after a rejected load
module up_down_counter_mod #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH,
  parameter bit     ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             load_err
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "up_down_counter_mod: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
      $fatal(1, "up_down_counter_mod: MODULUS out of range 2..2**WIDTH");
    end
  endgenerate

  // MODULUS itself needs WIDTH+1 bits when it equals 2**WIDTH; MODULUS-1
  // always fits in WIDTH bits, so the step arithmetic stays at WIDTH bits.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] term;
  logic             at_term;
  logic             load_ok;
  logic [WIDTH-1:0] step;

  assign term    = up_dn ? TOP : '0;
  assign at_term = (count == term);
  assign load_ok = ({1'b0, load_val} < MOD_X);
  assign tc      = en & ~load & ~done & at_term;

  // Wrapping step; count never exceeds TOP so count+1 cannot overflow.
  always_comb begin
    step = count;
    if (up_dn) step = (count == TOP) ? '0 : count + 1'b1;
    else       step = (count == '0) ? TOP : count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (load) begin
        // Rejected loads leave count and done untouched.
        if (load_ok) begin
          count <= load_val;
          done  <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en && !done) begin
        // done can only ever be set in one-shot builds, so this gate is
        // a no-op for wrapping counters.
        if (ONESHOT && at_term) done  <= 1'b1;
        else                    count <= step;
      end
    end
  end

endmodule
